i2s_audio_tx: RTL and testbench
===============================

Name: i2s_audio_tx

Overview:
- Sequences the 16-bit stereo audio datapath onto the board's I2S DAC pins (hp_bck/hp_ws/hp_din).
- Replaces the free-running integer bit-clock divider with a fractional (Bresenham) bit-clock generator, giving an exact average rate.
- Adds a one-entry sample holding register with valid/ready handshake, frame sequencing and underrun accounting.
- Sits in the board top level between the core's audio output and the amplifier pins.

Parameters:
CLK_HZ, 32000000, frequency of clk32 in Hz
SAMPLE_RATE, 48000, output frame rate in Hz; 32 bck periods per frame
ACC_W, 27, phase accumulator width; must hold CLK_HZ + 64*SAMPLE_RATE

Ports:
clk32  in  1  system clock, all logic in this domain
reset  in  1  asynchronous, active-high reset
enable  in  1  sync; low holds the block in its reset state
mute  in  1  sync; forces hp_din to 0, sequencing continues
sample_l  in  16  left sample, two's complement
sample_r  in  16  right sample, two's complement
sample_valid  in  1  producer offers sample_l/sample_r
sample_ready  out  1  holding register empty; transfer when valid&ready
hp_bck  out  1  I2S bit clock
hp_ws  out  1  I2S word select, 0 = left
hp_din  out  1  I2S serial data, MSB first
frame_start  out  1  one-cycle pulse on entry to slot 0
underrun_cnt  out  8  saturating count of frames started without a held sample

Behaviour:
- Reset (async) or enable=0 (sync) sets the following state:
  - acc=0, hp_bck=0, slot=31, hp_ws=0, hp_din=0, frame_start=0.
  - Holding register empty, so sample_ready=1 (sample_ready=0 while enable=0).
  - Shift data=0, underrun_cnt=0.
- Rate generator, evaluated each clk32:
  - INC = 64*SAMPLE_RATE.
  - If acc+INC >= CLK_HZ: acc <= acc+INC-CLK_HZ and a toggle event fires; else acc <= acc+INC.
  - Each toggle event inverts hp_bck.
  - With defaults this gives exactly 96000 toggles per 1,000,000 cycles from reset.
- Rising toggle (hp_bck 0->1): nothing else changes.
- Falling toggle (hp_bck 1->0): slot <= slot+1 mod 32. In the same cycle hp_ws and hp_din are updated for the new slot n.
- hp_ws = 1 for n in 15..30, else 0. WS leads each word's MSB by one slot.
- hp_din:
  - Slots 0..15: left bit (15-n).
  - Slots 16..31: right bit (31-n).
  - Forced to 0 while mute=1.
- Frame load occurs on the falling toggle entering slot 0; frame_start pulses that cycle.
  - If the holding register is full: frame shift data <= held pair; holding register becomes empty.
  - If it is empty: frame shift data <= 0 (silence) and underrun_cnt increments, saturating at 255.
- Handshake:
  - sample_ready = holding register empty.
  - valid&ready captures sample_l/sample_r into the holding register, which becomes full the next cycle.
  - A capture in the same cycle as a frame load does not bypass. That frame takes the empty-register path (underrun) and the captured pair plays next frame.
  - sample_valid while not ready is ignored; the producer holds its data.
- Latency: a pair accepted before a frame load appears with the left MSB in slot 0 of that frame.
- Outputs are registered; no combinational path from inputs to the hp_* pins.
- Reset mid-frame: all outputs return to their reset values immediately.
  - The first falling toggle after reset enters slot 0 and performs a frame load.
  - Any partially sent word is discarded.

Test Plan:
- Reset/idle: hold reset, then release with no samples.
  - During reset: hp_bck=hp_ws=hp_din=0, sample_ready=1, underrun_cnt=0.
  - After release: first frame_start occurs in cycle 21 (second toggle) and underrun_cnt becomes 1.
- Rate: run 1,000,000 clk32 cycles after reset.
  - Exactly 48000 rising hp_bck edges, 1500 frame_start pulses.
  - High/low phases are each 10 or 11 cycles.
- Bit order: offer L=16'hA5C3, R=16'h3C5A before the first frame.
  - Sampling hp_din on rising bck for slots 0..31 yields A5C3 then 3C5A, MSB first.
  - hp_ws is 1 exactly for slots 15..30.
- Underrun/saturation: never assert sample_valid for 300 frames.
  - underrun_cnt reaches 255 and stays there.
  - hp_din stays 0 throughout.
- Backpressure/collision:
  - Hold sample_valid=1 continuously: sample_ready is 1 for one cycle per frame and every frame plays a new pair.
  - Assert valid only in the frame-load cycle: that frame is an underrun and the pair plays in the following frame.
- Mid-frame reset and mute:
  - Reset asserted at slot 20: the next frame restarts at slot 0 with fresh data.
  - mute=1: hp_din=0 while hp_bck, hp_ws and the handshake are unchanged.

Source files
------------

// File: rtl/i2s_audio_tx.sv
// rtl/i2s_audio_tx.sv - I2S stereo transmitter with fractional bit clock and one-entry sample holding register
module i2s_audio_tx #(
  parameter int CLK_HZ      = 32000000,
  parameter int SAMPLE_RATE = 48000,
  parameter int ACC_W       = 27
) (
  input  logic        clk32,
  input  logic        reset,
  input  logic        enable,
  input  logic        mute,
  input  logic [15:0] sample_l,
  input  logic [15:0] sample_r,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic        hp_bck,
  output logic        hp_ws,
  output logic        hp_din,
  output logic        frame_start,
  output logic [7:0]  underrun_cnt
);

  localparam logic [ACC_W-1:0] INC   = ACC_W'(64 * SAMPLE_RATE);
  localparam logic [ACC_W-1:0] LIMIT = ACC_W'(CLK_HZ);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_sum;
  logic             toggle;
  logic             fall;
  logic             load;
  logic [4:0]       slot;
  logic [4:0]       slot_nxt;
  logic             hold_full;
  logic [31:0]      hold_data;
  logic [31:0]      frame_data;
  logic [31:0]      frame_nxt;

  // Bresenham step: the accumulator carries the fractional remainder so the
  // average toggle rate is exactly INC/LIMIT of clk32.
  always_comb begin
    acc_sum   = acc + INC;
    toggle    = (acc_sum >= LIMIT);
    fall      = toggle && hp_bck;
    slot_nxt  = slot + 5'd1;
    load      = fall && (slot_nxt == 5'd0);
    frame_nxt = frame_data;
    if (load) begin
      frame_nxt = hold_full ? hold_data : 32'd0;
    end
  end

  assign sample_ready = enable && !hold_full;

  always_ff @(posedge clk32 or posedge reset) begin
    if (reset) begin
      acc          <= '0;
      hp_bck       <= 1'b0;
      hp_ws        <= 1'b0;
      hp_din       <= 1'b0;
      frame_start  <= 1'b0;
      slot         <= 5'd31;
      hold_full    <= 1'b0;
      hold_data    <= '0;
      frame_data   <= '0;
      underrun_cnt <= '0;
    end else if (!enable) begin
      acc          <= '0;
      hp_bck       <= 1'b0;
      hp_ws        <= 1'b0;
      hp_din       <= 1'b0;
      frame_start  <= 1'b0;
      slot         <= 5'd31;
      hold_full    <= 1'b0;
      hold_data    <= '0;
      frame_data   <= '0;
      underrun_cnt <= '0;
    end else begin
      acc         <= toggle ? (acc_sum - LIMIT) : acc_sum;
      frame_start <= load;
      frame_data  <= frame_nxt;
      if (toggle) begin
        hp_bck <= ~hp_bck;
      end
      // WS runs one slot ahead of the data so it changes before each word's MSB.
      if (fall) begin
        slot  <= slot_nxt;
        hp_ws <= (slot_nxt >= 5'd15) && (slot_nxt != 5'd31);
      end
      if (mute) begin
        hp_din <= 1'b0;
      end else if (fall) begin
        hp_din <= frame_nxt[5'd31 - slot_nxt];
      end
      // A capture coinciding with a load is not bypassed; it waits for the next frame.
      if (load && hold_full) begin
        hold_full <= 1'b0;
      end else if (sample_valid && sample_ready) begin
        hold_full <= 1'b1;
        hold_data <= {sample_l, sample_r};
      end
      if (load && !hold_full && (underrun_cnt != 8'hFF)) begin
        underrun_cnt <= underrun_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_i2s_audio_tx.sv
// tb/tb_i2s_audio_tx.sv - directed self-checking bench for i2s_audio_tx
module tb_i2s_audio_tx;

  logic        clk32 = 1'b0;
  logic        rst = 1'b1;
  logic        rst_f = 1'b1;
  logic        enable = 1'b1;
  logic        mute = 1'b0;
  logic [15:0] sl = '0;
  logic [15:0] sr = '0;
  logic        valid = 1'b0;
  logic        sample_ready, hp_bck, hp_ws, hp_din, frame_start;
  logic [7:0]  underrun_cnt;
  logic        f_ready, f_bck, f_ws, f_din, f_fs;
  logic [7:0]  f_ucnt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk32 = ~clk32;

  i2s_audio_tx dut (
    .clk32(clk32), .reset(rst), .enable(enable), .mute(mute),
    .sample_l(sl), .sample_r(sr), .sample_valid(valid), .sample_ready(sample_ready),
    .hp_bck(hp_bck), .hp_ws(hp_ws), .hp_din(hp_din), .frame_start(frame_start),
    .underrun_cnt(underrun_cnt)
  );

  // Fast-rate instance: a frame every 128 cycles so saturation is reachable quickly.
  i2s_audio_tx #(.CLK_HZ(128), .SAMPLE_RATE(1), .ACC_W(27)) u_fast (
    .clk32(clk32), .reset(rst_f), .enable(1'b1), .mute(1'b0),
    .sample_l(16'h0000), .sample_r(16'h0000), .sample_valid(1'b0), .sample_ready(f_ready),
    .hp_bck(f_bck), .hp_ws(f_ws), .hp_din(f_din), .frame_start(f_fs),
    .underrun_cnt(f_ucnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk32);
      #1;
    end
  endtask

  task automatic reset_pulse();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  task automatic wait_bck(input logic lvl, output bit ok);
    int i;
    ok = 1'b1;
    i = 0;
    while (hp_bck !== lvl) begin
      if (i == 40) begin
        ok = 1'b0;
        return;
      end
      step(1);
      i++;
    end
  endtask

  // Waits for frame_start, then samples hp_din/hp_ws on each rising bck for slots 0..31.
  task automatic capture_frame(input string tag, output logic [31:0] din, output logic [31:0] ws);
    int i;
    bit ok;
    din = '0;
    ws  = '0;
    ok  = 1'b1;
    i   = 0;
    while (frame_start !== 1'b1 && i < 2000) begin
      step(1);
      i++;
    end
    check({tag, "_fs_seen"}, frame_start, 1);
    if (frame_start === 1'b1) begin
      for (int s = 0; s < 32; s++) begin
        wait_bck(1'b1, ok);
        if (!ok) break;
        din[31-s] = hp_din;
        ws[31-s]  = hp_ws;
        if (s < 31) begin
          wait_bck(1'b0, ok);
          if (!ok) break;
        end
      end
    end
    check({tag, "_bck_run"}, ok, 1);
  endtask

  logic [31:0] din_v, ws_v;
  int first_bck, first_fs, rising, fs_cnt, last_t, pmin, pmax, rdy_cnt, idx, frames;
  logic prev, xfer, cap_done, din_seen;
  bit ok;
  logic [15:0] pl [4] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
  logic [15:0] pr [4] = '{16'h8001, 16'h8002, 16'h8003, 16'h8004};

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset and idle start-up
    step(3);
    check("rst_pins", {hp_bck, hp_ws, hp_din, frame_start}, 4'b0000);
    check("rst_ready", sample_ready, 1);
    check("rst_ucnt", underrun_cnt, 0);
    rst = 1'b0;
    first_bck = 0;
    first_fs = 0;
    for (int c = 1; c <= 30; c++) begin
      step(1);
      if (hp_bck === 1'b1 && first_bck == 0) first_bck = c;
      if (frame_start === 1'b1 && first_fs == 0) first_fs = c;
    end
    check("first_toggle_cycle", first_bck, 11);
    check("first_fs_cycle", first_fs, 21);
    check("idle_ucnt", underrun_cnt, 1);

    enable = 1'b0;
    step(1);
    check("dis_ready", sample_ready, 0);
    check("dis_ucnt", underrun_cnt, 0);
    check("dis_pins", {hp_bck, hp_ws, hp_din}, 3'b000);
    enable = 1'b1;

    // Rate over 12000 cycles: 1152 toggles exactly
    reset_pulse();
    rising = 0; fs_cnt = 0; last_t = 0; pmin = 99; pmax = 0;
    prev = hp_bck;
    for (int c = 1; c <= 12000; c++) begin
      step(1);
      if (hp_bck !== prev) begin
        if (last_t != 0) begin
          if (c - last_t < pmin) pmin = c - last_t;
          if (c - last_t > pmax) pmax = c - last_t;
        end
        last_t = c;
        if (hp_bck === 1'b1) rising++;
      end
      prev = hp_bck;
      if (frame_start === 1'b1) fs_cnt++;
    end
    check("rate_rising", rising, 576);
    check("rate_frames", fs_cnt, 18);
    check("phase_min", pmin, 10);
    check("phase_max", pmax, 11);

    // Bit order
    rst = 1'b1;
    step(1);
    sl = 16'hA5C3; sr = 16'h3C5A; valid = 1'b1;
    rst = 1'b0;
    step(1);
    check("bits_ready_after_xfer", sample_ready, 0);
    valid = 1'b0;
    capture_frame("bits", din_v, ws_v);
    check("bits_din", din_v, 32'hA5C33C5A);
    check("bits_ws", ws_v, 32'h0001FFFE);
    check("bits_ucnt", underrun_cnt, 0);

    // Continuous valid: one ready cycle per frame, a fresh pair every frame
    rst = 1'b1;
    step(1);
    sl = pl[0]; sr = pr[0]; valid = 1'b1;
    rst = 1'b0;
    cap_done = 1'b0; rdy_cnt = 0; idx = 0;
    fork
      begin
        for (int g = 0; g < 5000 && !cap_done; g++) begin
          xfer = valid && sample_ready;
          if (sample_ready === 1'b1) rdy_cnt++;
          step(1);
          if (xfer && idx < 3) begin
            idx++;
            sl = pl[idx];
            sr = pr[idx];
          end
        end
      end
      begin
        for (int f = 0; f < 3; f++) begin
          capture_frame("bp", din_v, ws_v);
          check($sformatf("bp_frame%0d", f), din_v, {pl[f], pr[f]});
        end
        cap_done = 1'b1;
      end
    join
    valid = 1'b0;
    check("bp_ready_cycles", rdy_cnt, 4);
    check("bp_ucnt", underrun_cnt, 0);

    // Valid only in the frame-load cycle
    reset_pulse();
    step(20);
    sl = 16'hBEEF; sr = 16'h1234; valid = 1'b1;
    step(1);
    valid = 1'b0;
    check("col_fs", frame_start, 1);
    check("col_ucnt", underrun_cnt, 1);
    check("col_ready", sample_ready, 0);
    step(1);
    capture_frame("col", din_v, ws_v);
    check("col_din", din_v, 32'hBEEF1234);
    check("col_ucnt_after", underrun_cnt, 1);

    // Reset at slot 20
    rst = 1'b1;
    step(1);
    sl = 16'h1357; sr = 16'h9BDF; valid = 1'b1;
    rst = 1'b0;
    step(1);
    valid = 1'b0;
    for (int i = 0; i < 2000 && frame_start !== 1'b1; i++) step(1);
    check("mid_fs_seen", frame_start, 1);
    for (int s = 0; s < 20; s++) begin
      wait_bck(1'b1, ok);
      if (ok) wait_bck(1'b0, ok);
    end
    check("mid_slot20_ws_din", {hp_ws, hp_din}, 2'b11);
    #1 rst = 1'b1;
    #1;
    check("mid_rst_pins", {hp_bck, hp_ws, hp_din, frame_start}, 4'b0000);
    check("mid_rst_ready", sample_ready, 1);
    check("mid_rst_ucnt", underrun_cnt, 0);
    step(2);
    sl = 16'h2468; sr = 16'hACE0; valid = 1'b1;
    rst = 1'b0;
    step(1);
    valid = 1'b0;
    capture_frame("mid", din_v, ws_v);
    check("mid_din", din_v, 32'h2468ACE0);
    check("mid_ucnt", underrun_cnt, 0);

    // Mute
    sl = 16'hF0F0; sr = 16'h0F0F; valid = 1'b1;
    step(1);
    valid = 1'b0;
    mute = 1'b1;
    capture_frame("mute", din_v, ws_v);
    check("mute_din", din_v, 0);
    check("mute_ws", ws_v, 32'h0001FFFE);
    check("mute_ready", sample_ready, 1);
    check("mute_ucnt", underrun_cnt, 0);
    mute = 1'b0;
    sl = 16'h7E81; sr = 16'h8E71; valid = 1'b1;
    step(1);
    valid = 1'b0;
    capture_frame("unmute", din_v, ws_v);
    check("unmute_din", din_v, 32'h7E818E71);

    // Underrun saturation on the fast instance
    rst_f = 1'b0;
    frames = 0;
    din_seen = 1'b0;
    for (int c = 0; c < 39000 && frames < 300; c++) begin
      step(1);
      if (f_din === 1'b1) din_seen = 1'b1;
      if (f_fs === 1'b1) begin
        frames++;
        if (frames == 254) check("sat_254", f_ucnt, 254);
        if (frames == 256) check("sat_256", f_ucnt, 255);
      end
    end
    check("sat_frames", frames, 300);
    check("sat_final", f_ucnt, 255);
    check("sat_din_silent", din_seen, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
